// File: rtl/stupidrv_pkg.sv
// stupidrv_pkg: shared types and constants for the stupidrv memory sequencer
//   state_e  : sequencer FSM states
//   NOP      : instruction presented to the core while no real fetch has landed
//   RST_HOLD : extra cycles held in RST after core_reset drops
package stupidrv_pkg;
   typedef enum logic [2:0] {RST, FETCH, DECODE, DATA, EXEC} state_e;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [1:0] RST_HOLD = 2'd2;
endpackage

// File: rtl/stupidrv_memctrl.sv
// stupidrv_memctrl: runs the stupidrv core from one shared single-port memory
//   clock, resetn          : clock and synchronous active-low reset
//   halt                   : holds the core stalled in EXEC
//   core_reset, core_stall : reset and stall driven to the core
//   core_imem_*            : next-pc from core, registered instruction to core
//   core_dmem_*            : core data request in, registered load data out
//   mem_*                  : shared memory port (valid/ready handshake)
//   instret                : retired-instruction count
module stupidrv_memctrl
   import stupidrv_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        halt,
   output logic        core_reset,
   output logic        core_stall,
   input  logic [31:0] core_imem_addr,
   output logic [31:0] core_imem_data,
   input  logic        core_dmem_valid,
   input  logic [31:0] core_dmem_addr,
   input  logic [3:0]  core_dmem_wstrb,
   input  logic [31:0] core_dmem_wdata,
   output logic [31:0] core_dmem_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] instret
);
   state_e      state_q, state_d;
   logic [1:0]  rst_cnt_q, rst_cnt_d;
   logic        core_reset_q;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] imem_q, imem_d;
   logic [31:0] dmem_rdata_q, dmem_rdata_d;
   logic [31:0] instret_q, instret_d;
   logic [31:0] data_addr_q, data_addr_d;
   logic [3:0]  data_wstrb_q, data_wstrb_d;
   logic [31:0] data_wdata_q, data_wdata_d;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= RST;
         rst_cnt_q    <= 2'd0;
         core_reset_q <= 1'b1;
         fetch_addr_q <= RESET_ADDR;
         imem_q       <= NOP;
         dmem_rdata_q <= 32'd0;
         instret_q    <= 32'd0;
         data_addr_q  <= 32'd0;
         data_wstrb_q <= 4'd0;
         data_wdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         core_reset_q <= 1'b0;
         fetch_addr_q <= fetch_addr_d;
         imem_q       <= imem_d;
         dmem_rdata_q <= dmem_rdata_d;
         instret_q    <= instret_d;
         data_addr_q  <= data_addr_d;
         data_wstrb_q <= data_wstrb_d;
         data_wdata_q <= data_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      fetch_addr_d = fetch_addr_q;
      imem_d       = imem_q;
      dmem_rdata_d = dmem_rdata_q;
      instret_d    = instret_q;
      data_addr_d  = data_addr_q;
      data_wstrb_d = data_wstrb_q;
      data_wdata_d = data_wdata_q;
      case (state_q)
         RST: begin
            // hold long enough for the core's own registered reset to clear
            rst_cnt_d = rst_cnt_q == RST_HOLD ? rst_cnt_q : rst_cnt_q + 2'd1;
            state_d   = rst_cnt_q == RST_HOLD ? FETCH : RST;
         end
         FETCH: begin
            imem_d  = mem_ready ? mem_rdata : imem_q;
            state_d = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            // the core's data request is only trustworthy once it sees the new instruction
            data_addr_d  = core_dmem_valid ? core_dmem_addr : data_addr_q;
            data_wstrb_d = core_dmem_valid ? core_dmem_wstrb : data_wstrb_q;
            data_wdata_d = core_dmem_valid ? core_dmem_wdata : data_wdata_q;
            state_d      = core_dmem_valid ? DATA : EXEC;
         end
         DATA: begin
            dmem_rdata_d = mem_ready ? mem_rdata : dmem_rdata_q;
            state_d      = mem_ready ? EXEC : DATA;
         end
         EXEC: begin
            // core commits on this edge when unstalled; capture its next pc
            fetch_addr_d = halt ? fetch_addr_q : core_imem_addr;
            instret_d    = halt ? instret_q : instret_q + 32'd1;
            state_d      = halt ? EXEC : FETCH;
         end
         default: state_d = RST;
      endcase
   end

   always_comb begin
      mem_valid  = state_q == FETCH || state_q == DATA;
      mem_addr   = (state_q == DATA ? data_addr_q : fetch_addr_q) & 32'hFFFF_FFFC;
      mem_wstrb  = state_q == DATA ? data_wstrb_q : 4'h0;
      mem_wdata  = data_wdata_q;
      core_stall = state_q == EXEC ? halt : 1'b1;
   end

   assign core_reset      = core_reset_q;
   assign core_imem_data  = imem_q;
   assign core_dmem_rdata = dmem_rdata_q;
   assign instret         = instret_q;
endmodule

// File: tb/tb_stupidrv_memctrl.sv
// tb_stupidrv_memctrl: directed bench with a tiny core model, a wait-state memory and an access scoreboard
module tb_stupidrv_memctrl;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        halt = 1'b0;
   logic        core_reset, core_stall;
   logic [31:0] core_imem_addr, core_imem_data;
   logic        core_dmem_valid;
   logic [31:0] core_dmem_addr;
   logic [3:0]  core_dmem_wstrb;
   logic [31:0] core_dmem_wdata, core_dmem_rdata;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [31:0] instret;

   always #5 clock = ~clock;

   stupidrv_memctrl #(.RESET_ADDR(32'h0)) dut (
      .clock(clock), .resetn(resetn), .halt(halt),
      .core_reset(core_reset), .core_stall(core_stall),
      .core_imem_addr(core_imem_addr), .core_imem_data(core_imem_data),
      .core_dmem_valid(core_dmem_valid), .core_dmem_addr(core_dmem_addr),
      .core_dmem_wstrb(core_dmem_wstrb), .core_dmem_wdata(core_dmem_wdata),
      .core_dmem_rdata(core_dmem_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .instret(instret)
   );

   // memory: ready after ws wait cycles, abandoned requests restart the count
   logic [31:0] mem [0:127];
   int          ws = 0;
   int          wcnt = 0;
   logic        ld_en = 1'b0;
   logic [6:0]  ld_idx = 7'd0;
   logic [31:0] ld_data = 32'd0;
   assign mem_ready = mem_valid && (wcnt == ws);
   assign mem_rdata = mem[mem_addr[8:2]];
   always @(posedge clock) begin
      if (ld_en) mem[ld_idx] <= ld_data;
      else if (mem_valid && mem_ready)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wcnt <= (mem_valid && !mem_ready) ? wcnt + 1 : 0;
   end

   // core model: ADDI, LW, SW, JALR; anything else is a no-op
   logic [31:0] x [0:31];
   logic [31:0] pc;
   int          ncommit = 0;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, rv1, rv2;
   logic        is_addi, is_lw, is_sw, is_jalr;
   assign op      = core_imem_data[6:0];
   assign f3      = core_imem_data[14:12];
   assign rd      = core_imem_data[11:7];
   assign rs1     = core_imem_data[19:15];
   assign rs2     = core_imem_data[24:20];
   assign imm_i   = {{20{core_imem_data[31]}}, core_imem_data[31:20]};
   assign imm_s   = {{20{core_imem_data[31]}}, core_imem_data[31:25], core_imem_data[11:7]};
   assign rv1     = x[rs1];
   assign rv2     = x[rs2];
   assign is_addi = op == 7'h13 && f3 == 3'd0;
   assign is_lw   = op == 7'h03 && f3 == 3'd2;
   assign is_sw   = op == 7'h23 && f3 == 3'd2;
   assign is_jalr = op == 7'h67 && f3 == 3'd0;
   assign core_imem_addr  = is_jalr ? ((rv1 + imm_i) & ~32'h1) : pc + 32'd4;
   assign core_dmem_valid = is_lw || is_sw;
   assign core_dmem_addr  = rv1 + (is_sw ? imm_s : imm_i);
   assign core_dmem_wstrb = is_sw ? 4'hF : 4'h0;
   assign core_dmem_wdata = rv2;
   always @(posedge clock) begin
      if (core_reset) begin
         pc <= 32'd0;
         for (int i = 0; i < 32; i++) x[i] <= 32'd0;
      end else if (!core_stall) begin
         pc <= core_imem_addr;
         ncommit <= ncommit + 1;
         if (rd != 5'd0)
            x[rd] <= is_lw ? core_dmem_rdata : is_jalr ? pc + 32'd4 : is_addi ? rv1 + imm_i : x[rd];
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } acc_t;
   acc_t        exp_q[$];
   int          commit_cyc[$];
   int          n_assert = 0, n_fail = 0, cyc = 0, prev_nc = 0, low_cnt = 0, bad = 0, b = 0;
   logic        prev_v = 1'b0, prev_r = 1'b0;
   logic [31:0] prev_a = 32'd0, prev_d = 32'd0;
   logic [3:0]  prev_s = 4'd0;
   acc_t        e;

   function automatic logic [31:0] img(input int i);
      case (i)
         0:  return 32'h0050_0093;
         1:  return 32'h0030_8113;
         2:  return 32'h0200_2103;
         3:  return 32'h0420_2023;
         4:  return 32'h0240_2283;
         5:  return 32'h0002_80E7;
         8:  return 32'h1234_5678;
         9:  return 32'h0000_0102;
         64: return 32'h0070_0193;
         65: return 32'h0000_0013;
         66: return 32'h0430_2223;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      exp_q.push_back('{addr: a, wstrb: s, wdata: d});
   endtask

   task automatic tick();
      @(negedge clock);
      cyc++;
      if (prev_v && !prev_r && mem_valid) begin
         chk("hold_addr", mem_addr, prev_a);
         chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, prev_s});
         chk("hold_wdata", mem_wdata, prev_d);
      end
      if (mem_valid && mem_ready) begin
         if (exp_q.size() == 0) chk("sb_pending", 32'd0, 32'd1);
         else begin
            e = exp_q.pop_front();
            chk("sb_addr", mem_addr, e.addr);
            chk("sb_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
            if (e.wstrb != 4'd0) chk("sb_wdata", mem_wdata, e.wdata);
         end
      end
      if (ncommit != prev_nc) commit_cyc.push_back(cyc);
      prev_nc = ncommit;
      if (!core_stall && !core_reset) low_cnt++;
      prev_v = mem_valid;
      prev_r = mem_ready;
      prev_a = mem_addr;
      prev_s = mem_wstrb;
      prev_d = mem_wdata;
   endtask

   task automatic run_to(input int n);
      int k = 0;
      while (ncommit < n && k < 100) begin
         tick();
         k++;
      end
      chk("run_to_budget", 32'(ncommit), 32'(n));
   endtask

   initial begin
      push(32'h00, 4'h0, 0); push(32'h04, 4'h0, 0); push(32'h08, 4'h0, 0);
      push(32'h20, 4'h0, 0); push(32'h0C, 4'h0, 0); push(32'h40, 4'hF, 32'h1234_5678);
      push(32'h10, 4'h0, 0); push(32'h24, 4'h0, 0); push(32'h14, 4'h0, 0);
      push(32'h100, 4'h0, 0); push(32'h104, 4'h0, 0); push(32'h108, 4'h0, 0);
      push(32'h00, 4'h0, 0);
      ld_en = 1'b1;
      for (int i = 0; i < 128; i++) begin
         ld_idx = 7'(i);
         ld_data = img(i);
         tick();
      end
      ld_en = 1'b0;
      tick();
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_core_stall", 32'(core_stall), 1);
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_imem_data", core_imem_data, 32'h0000_0013);
      chk("rst_dmem_rdata", core_dmem_rdata, 0);
      chk("rst_instret", instret, 0);
      resetn = 1'b1;
      tick();
      chk("core_reset_release", 32'(core_reset), 0);
      tick();
      chk("rst_hold_no_valid", 32'(mem_valid), 0);
      tick();
      chk("first_fetch_valid", 32'(mem_valid), 1);
      chk("first_fetch_addr", mem_addr, 0);
      run_to(2);
      chk("instret_2", instret, 2);
      chk("x2_addi", x[2], 8);
      chk("alu_latency", 32'(commit_cyc[1] - commit_cyc[0]), 3);
      run_to(6);
      chk("instret_6", instret, 6);
      chk("x2_lw", x[2], 32'h1234_5678);
      chk("x5_lw", x[5], 32'h102);
      chk("x1_jalr", x[1], 32'h18);
      chk("mem_sw", mem[16], 32'h1234_5678);
      chk("lw_latency", 32'(commit_cyc[2] - commit_cyc[1]), 4);
      chk("sw_latency", 32'(commit_cyc[3] - commit_cyc[2]), 4);
      chk("lw2_latency", 32'(commit_cyc[4] - commit_cyc[3]), 4);
      chk("jalr_latency", 32'(commit_cyc[5] - commit_cyc[4]), 3);
      chk("stall_low_cycles", 32'(low_cnt), 6);
      halt = 1'b1;
      tick();
      tick();
      ws = 2;
      bad = 0;
      repeat (4) begin
         if (mem_valid || !core_stall) bad++;
         tick();
      end
      chk("halt_quiet", 32'(bad), 0);
      chk("halt_instret", instret, 6);
      chk("halt_commits", 32'(ncommit), 6);
      halt = 1'b0;
      tick();
      chk("unhalt_commit", 32'(ncommit), 7);
      chk("unhalt_instret", instret, 7);
      chk("unhalt_fetch", 32'(mem_valid), 1);
      chk("unhalt_addr", mem_addr, 32'h104);
      run_to(8);
      chk("wait_latency", 32'(commit_cyc[7] - commit_cyc[6]), 5);
      chk("wait_instret", instret, 8);
      b = 0;
      while (!(mem_valid && mem_wstrb != 4'd0) && b < 20) begin
         tick();
         b++;
      end
      chk("data_reached", 32'(mem_valid && mem_wstrb != 4'd0), 1);
      chk("data_addr", mem_addr, 32'h44);
      chk("data_wdata", mem_wdata, 7);
      chk("data_waiting", 32'(mem_ready), 0);
      resetn = 1'b0;
      tick();
      chk("abort_valid", 32'(mem_valid), 0);
      chk("abort_core_reset", 32'(core_reset), 1);
      chk("abort_stall", 32'(core_stall), 1);
      chk("abort_imem", core_imem_data, 32'h0000_0013);
      chk("abort_instret", instret, 0);
      chk("abort_no_write", mem[17], 0);
      ws = 0;
      resetn = 1'b1;
      tick();
      tick();
      chk("restart_hold", 32'(mem_valid), 0);
      tick();
      chk("restart_valid", 32'(mem_valid), 1);
      chk("restart_addr", mem_addr, 0);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/stupidrv_memctrl.md
Name: stupidrv_memctrl

Overview:
Sequencer that lets the stupidrv core run from one shared single-port memory. The core expects combinational instruction and data ports. This block serialises each instruction into a fetch access and an optional data access on the memory port, and gates the core with stall so that exactly one instruction commits per sequence. It also owns the core's active-high reset and an instruction-retired counter.

Parameters:
RESET_ADDR, 32'h0000_0000, first fetch address; must equal the core's RESET_ADDR.

Ports:
clock  in  1  clock
resetn  in  1  synchronous reset, active-low
halt  in  1  when 1, holds the core stalled before commit
core_reset  out  1  active-high reset to core
core_stall  out  1  stall to core
core_imem_addr  in  32  core's next-instruction address
core_imem_data  out  32  current instruction to core (registered)
core_dmem_valid  in  1  core data request (combinational from instruction)
core_dmem_addr  in  32  core data address
core_dmem_wstrb  in  4  byte write strobes; 0 means read
core_dmem_wdata  in  32  core write data
core_dmem_rdata  out  32  load data to core (registered)
mem_valid  out  1  memory request
mem_addr  out  32  word address, bits [1:0] forced to 0
mem_wstrb  out  4  byte strobes; 0 means read
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  request accepted/completed this cycle
instret  out  32  retired-instruction count

Behaviour:
- Clock is named clock; reset is synchronous, active-low, port resetn.
- FSM states: RST, FETCH, DECODE, DATA, EXEC.
- While resetn=0:
  - state=RST; core_reset=1, core_stall=1, mem_valid=0.
  - core_imem_data=32'h0000_0013 (NOP), core_dmem_rdata=0, instret=0, fetch_addr=RESET_ADDR, rst_cnt=0.
- RST:
  - core_reset deasserts in the first cycle after resetn=1.
  - Stay in RST 2 more cycles (rst_cnt), covering the core's own reset_q cycle, then go to FETCH.
- FETCH:
  - mem_valid=1, mem_addr=fetch_addr, mem_wstrb=0.
  - On mem_ready: core_imem_data<=mem_rdata, go to DECODE.
- DECODE (1 cycle; core now sees the new instruction):
  - If core_dmem_valid: latch addr/wstrb/wdata into data_* registers, go to DATA.
  - Otherwise go to EXEC.
- DATA:
  - mem_valid=1; mem_addr/wstrb/wdata come from the data_* registers.
  - On mem_ready: core_dmem_rdata<=mem_rdata (also on writes), go to EXEC.
- EXEC:
  - core_stall=halt. Remain in EXEC while halt=1.
  - In the cycle with halt=0: fetch_addr<=core_imem_addr, instret<=instret+1 (wraps mod 2^32), go to FETCH.
- core_stall=1 in every state except EXEC.
- Exactly one core commit per instruction.
- Memory handshake:
  - mem_ready may rise in the same cycle mem_valid rises.
  - mem_addr, mem_wstrb and mem_wdata stay stable while mem_valid=1 and mem_ready=0.
  - mem_valid drops in the cycle after acceptance, except that DATA follows FETCH only via DECODE, so it is never back-to-back.
- Latency with zero-wait memory: 3 cycles per non-memory instruction, 4 per load/store; each wait state adds 1.
- mem_ready while mem_valid=0 is ignored.
- halt asserted outside EXEC has no effect until EXEC is reached; in-flight accesses complete.
- resetn=0 mid-access: the request is abandoned next cycle (mem_valid=0); the memory must tolerate the abandonment. All registers return to reset values.
- Outputs must not depend combinationally on mem_rdata. core_dmem_* inputs are sampled only in DECODE.

Decomposition:
- Shared package stupidrv_pkg holds the FSM state enum (RST, FETCH, DECODE, DATA, EXEC), the NOP constant 32'h0000_0013, and the reset-hold count constant 2.
- Single flat module, no sub-module; the memory port is simple enough to stay inline.

Test Plan:
- Reset then 0-wait memory, RESET_ADDR=0, mem[0]=ADDI x1,x0,5, mem[4]=ADDI x2,x1,3:
  - first mem_valid 3 cycles after resetn rises, mem_addr=0;
  - commits 3 cycles apart; x2=8; instret=2.
- SW x2,16(x0) with x2=0x1234_5678:
  - FETCH, DECODE, DATA with mem_addr=0x10, wstrb=4'hF, wdata=0x12345678;
  - core_stall low for exactly 1 cycle.
- Memory with 2 wait states on each access:
  - mem_addr/wdata stable across the waits;
  - a non-memory instruction takes 5 cycles; instret increments once.
- halt=1 held for 4 cycles during EXEC:
  - core_stall=1 throughout, no fetch issued, instret unchanged;
  - after halt falls, the commit and next fetch occur next cycle.
- resetn=0 during a DATA wait state:
  - mem_valid=0 next cycle, core_reset=1, core_imem_data=0x00000013, instret=0;
  - after release, fetch restarts at RESET_ADDR.
- JALR x1,0(x5) with x5=0x100:
  - the next FETCH has mem_addr=0x100;
  - mem_addr for an unaligned core_imem_addr 0x102 is 0x100.
